// File: rtl/echo_timer_pkg.sv
// Shared types and default timing constants for the ultrasonic echo timer.
// States use a 3-bit encoding; defaults assume a 50 MHz clock.
package echo_timer_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_MEASURE   = 3'd3,
        S_LAUNCH    = 3'd4,
        S_WAIT_DONE = 3'd5,
        S_DRAIN     = 3'd6
    } state_e;

    localparam int unsigned TRIG_CYCLES_DEF    = 500;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 1900000;
    localparam int unsigned CNT_W_DEF          = 32;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Both flops clear on reset so no stale level survives it.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/echo_timer.sv
// Ultrasonic echo timer: trigger, measure echo width, launch multiplier.
// Define ECHO_TIMER_AUTO_EN for continuous back-to-back measurement.
module echo_timer
    import echo_timer_pkg::*;
#(
    parameter int unsigned TRIG_CYCLES    = TRIG_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned CNT_W          = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             echo,
    output logic             trig,
    output logic [CNT_W-1:0] op_a,
    output logic             init,
    input  logic             mult_done,
    output logic             busy,
    output logic             timeout
);

    localparam int TRIG_W = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;
    localparam int TMO_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    state_e            state_q, state_d;
    logic [TRIG_W-1:0] trig_cnt_q, trig_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0]  width_q, width_d;
    logic [CNT_W-1:0]  op_a_q, op_a_d;
    logic              echo_s;
    logic              tmo_hit;
    logic              width_max;

    sync_2ff u_sync (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (echo),
        .q_o    (echo_s)
    );

    assign tmo_hit   = (tmo_cnt_q == TMO_LIMIT);
    assign width_max = &width_q;

`ifdef ECHO_TIMER_AUTO_EN
    logic unused_start;
    assign unused_start = start;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            trig_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            width_q    <= '0;
            op_a_q     <= '0;
        end else begin
            state_q    <= state_d;
            trig_cnt_q <= trig_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            width_q    <= width_d;
            op_a_q     <= op_a_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        trig_cnt_d = trig_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        width_d    = width_q;
        op_a_d     = op_a_q;
        trig       = 1'b0;
        init       = 1'b0;
        timeout    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                trig_cnt_d = '0;
`ifdef ECHO_TIMER_AUTO_EN
                state_d = S_TRIG;
`else
                if (start) begin
                    state_d = S_TRIG;
                end
`endif
            end

            S_TRIG: begin
                trig = 1'b1;
                if (trig_cnt_q == TRIG_LAST) begin
                    tmo_cnt_d = '0;
                    state_d   = S_WAIT_RISE;
                end else begin
                    trig_cnt_d = trig_cnt_q + 1'b1;
                end
            end

            // Timeout is checked before the echo so it wins a tie.
            S_WAIT_RISE: begin
                if (tmo_hit) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    if (echo_s) begin
                        width_d = CNT_W'(1);
                        state_d = S_MEASURE;
                    end
                end
            end

            S_MEASURE: begin
                if (tmo_hit) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    if (echo_s) begin
                        if (!width_max) begin
                            width_d = width_q + 1'b1;
                        end
                    end else begin
                        op_a_d  = width_q;
                        state_d = S_LAUNCH;
                    end
                end
            end

            S_LAUNCH: begin
                init    = 1'b1;
                state_d = S_WAIT_DONE;
            end

            S_WAIT_DONE: begin
                if (mult_done) begin
                    state_d = S_DRAIN;
                end
            end

            // Hold off until done drops so init cannot re-fire on a stale level.
            S_DRAIN: begin
                if (!mult_done) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign op_a = op_a_q;

endmodule

// File: doc/echo_timer.md
ECHO_TIMER -- requirements
Module: echo_timer

Interface
REQ-001 SHALL have parameter TRIG_CYCLES, default 500, trigger pulse length in clk cycles (10 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1900000, maximum cycles from trigger end to echo end (38 ms at 50 MHz).
REQ-003 SHALL have parameter CNT_W, default 32, echo count and op_a width.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  measurement request, sampled in IDLE.
REQ-007 SHALL have port echo  input  1  raw ultrasonic echo, asynchronous to clk.
REQ-008 SHALL have port trig  output  1  sensor trigger pulse.
REQ-009 SHALL have port op_a  output  CNT_W  echo width in cycles, multiplier operand.
REQ-010 SHALL have port init  output  1  one-cycle multiplier start pulse.
REQ-011 SHALL have port mult_done  input  1  multiplier done level, may stay high about 10 cycles.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port timeout  output  1  one-cycle pulse when a measurement is aborted.

Function
REQ-014 SHALL pass echo through a two-flop synchronizer; all echo decisions SHALL use the synchronized value (echo_s).
REQ-015 SHALL implement states IDLE, TRIG, WAIT_RISE, MEASURE, LAUNCH, WAIT_DONE, DRAIN.
REQ-016 IDLE->TRIG when start=1; start in any other state SHALL be ignored, not queued.
REQ-017 TRIG SHALL drive trig=1 for exactly TRIG_CYCLES cycles, then go to WAIT_RISE; trig=0 in all other states.
REQ-018 Timeout counter SHALL clear on entry to WAIT_RISE and increment every cycle in WAIT_RISE and MEASURE.
REQ-019 WAIT_RISE->MEASURE on echo_s=1, loading the width counter with 1.
REQ-020 In MEASURE, the width counter SHALL increment each cycle with echo_s=1, saturating at 2^CNT_W-1 without wrap-around.
REQ-021 On echo_s=0 in MEASURE, op_a SHALL load the width count, which equals the number of cycles echo_s was high; the FSM then goes to LAUNCH.
REQ-022 In WAIT_RISE or MEASURE, a timeout count equal to TIMEOUT_CYCLES SHALL pulse timeout for one cycle, return to IDLE, leave op_a unchanged, and issue no init; timeout takes priority over a simultaneous echo edge.
REQ-023 LAUNCH SHALL assert init for exactly one cycle, then go to WAIT_DONE.
REQ-024 WAIT_DONE->DRAIN on mult_done=1; DRAIN->IDLE on mult_done=0, so init never re-fires while the multiplier is still in its done phase.
REQ-025 op_a SHALL hold stable from LAUNCH until the next successful MEASURE exit.

Reset
REQ-026 rst=0 SHALL immediately force state IDLE, trig=0, init=0, timeout=0, op_a=0, and clear all counters and synchronizer flops, including mid-operation.
REQ-027 After rst deasserts, the first measurement SHALL start only on a new start (or per REQ-028).

Configuration
REQ-028 With ECHO_TIMER_AUTO_EN defined, IDLE SHALL go to TRIG on the cycle after entry regardless of start (continuous measurement) and start is ignored; without it, behaviour SHALL follow REQ-016.

Structure
REQ-029 Package echo_timer_pkg SHALL hold the state enum (3-bit encoding) and the default TRIG_CYCLES/TIMEOUT_CYCLES constants.
REQ-030 The synchronizer SHALL be a separate sub-module sync_2ff; all other logic is in echo_timer.

Verification (TRIG_CYCLES=4, TIMEOUT_CYCLES=100, CNT_W=32)
REQ-031 start pulse in IDLE -> trig high exactly 4 cycles, busy high from next cycle.
REQ-032 echo high 37 cycles after trig -> op_a=37, single init pulse, no timeout.
REQ-033 echo never rises -> timeout pulse 100 cycles after WAIT_RISE entry, no init, busy low afterward; echo held high 150 cycles -> same timeout.
REQ-034 mult_done high 10 cycles after init, with start pulsed during that time -> busy falls only after mult_done falls, no second trig.
REQ-035 rst=0 during MEASURE -> trig, init, busy, op_a all 0 in the same cycle; a fresh start then yields a correct measurement.
REQ-036 ECHO_TIMER_AUTO_EN defined, start tied 0 -> back-to-back measurements, with trig re-issued one cycle after each DRAIN exit.
